// File: rtl/wb_conmax_slave_if_n_if.sv
// Bus bundle for one conmax slave port: NM Wishbone master ports on one side,
// a single Wishbone slave on the other.
//   slave  modport : view of the arbiter block (takes master requests and
//                    slave responses, drives master responses and slave request)
//   master modport : view of the surrounding environment (the opposite directions)
interface wb_conmax_slave_if_n_if #(
  parameter int NM = 8,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8
);
  logic [NM*DW-1:0] m_data_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM*DW-1:0] m_data_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    m_rty_o;
  logic [DW-1:0]    wb_data_i;
  logic             wb_ack_i;
  logic             wb_err_i;
  logic             wb_rty_i;
  logic [DW-1:0]    wb_data_o;
  logic [AW-1:0]    wb_addr_o;
  logic [SW-1:0]    wb_sel_o;
  logic             wb_we_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;

  modport slave (
    input  m_data_i, m_addr_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    input  wb_data_i, wb_ack_i, wb_err_i, wb_rty_i,
    output m_data_o, m_ack_o, m_err_o, m_rty_o,
    output wb_data_o, wb_addr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

  modport master (
    output m_data_i, m_addr_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output wb_data_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  m_data_o, m_ack_o, m_err_o, m_rty_o,
    input  wb_data_o, wb_addr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_conmax_slave_if_n.sv
// Conmax slave port: arbitrates NM Wishbone masters onto one slave with a
// registered grant, fixed / round-robin / priority+round-robin arbitration and
// a per-transfer watchdog that ends a hung transfer with an error.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   conf          : 2-bit priority per master (3 = highest), ARB_MODE 2 only
//   to_limit      : watchdog limit in stalled cycles, 0 disables
//   bus           : master-side and slave-side Wishbone signals
//   gnt_o         : current grant index
//   busy_o        : a grant is active
//   timeout_o     : one-cycle pulse on watchdog expiry
module wb_conmax_slave_if_n #(
  parameter int NM       = 8,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int SW       = DW / 8,
  parameter int ARB_MODE = 2,
  parameter int TO_W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [2*NM-1:0]        conf,
  input  logic [TO_W-1:0]        to_limit,
  wb_conmax_slave_if_n_if.slave  bus,
  output logic [$clog2(NM)-1:0]  gnt_o,
  output logic                   busy_o,
  output logic                   timeout_o
);
  localparam int GW = $clog2(NM);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d, ptr_q, ptr_d, win;
  logic [TO_W-1:0] wd_q, wd_d;

  logic [AW-1:0] addr_a [NM];
  logic [DW-1:0] data_a [NM];
  logic [SW-1:0] sel_a  [NM];
  logic [1:0]    lvl_a  [NM];

  for (genvar k = 0; k < NM; k++) begin : g_split
    assign addr_a[k] = bus.m_addr_i[k*AW +: AW];
    assign data_a[k] = bus.m_data_i[k*DW +: DW];
    assign sel_a[k]  = bus.m_sel_i[k*SW +: SW];
    assign lvl_a[k]  = conf[2*k +: 2];
  end

  logic          g_cyc, g_stb, s_resp, stall, expire;
  logic [NM-1:0] g_onehot;

  assign g_cyc    = bus.m_cyc_i[gnt_q];
  assign g_stb    = bus.m_stb_i[gnt_q];
  assign g_onehot = NM'(1) << gnt_q;
  assign s_resp   = bus.wb_ack_i | bus.wb_err_i | bus.wb_rty_i;
  // A response or a dropped cyc in the expiry cycle suppresses the timeout,
  // because either one removes the stall condition.
  assign stall    = (state_q == BUSY) & g_cyc & g_stb & ~s_resp;
  assign expire   = stall & (to_limit != '0) & (wd_q == to_limit - TO_W'(1));

  assign gnt_o         = gnt_q;
  assign bus.m_data_o  = {NM{bus.wb_data_i}};

  // Arbitration. In mode 2 the round-robin scan is restricted to requesters
  // sitting at the highest level present; modes 1 and 2 scan from ptr+1.
  logic [1:0]    top_lvl;
  logic [NM-1:0] rr_req;
  logic          win_found;
  int unsigned   idx;

  always_comb begin
    top_lvl   = '0;
    rr_req    = '0;
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NM; i++)
      if (bus.m_cyc_i[i] && lvl_a[i] > top_lvl) top_lvl = lvl_a[i];
    for (int unsigned i = 0; i < NM; i++)
      if (bus.m_cyc_i[i] && (ARB_MODE != 2 || lvl_a[i] == top_lvl)) rr_req[i] = 1'b1;
    if (ARB_MODE == 0) begin
      for (int unsigned i = 0; i < NM; i++)
        if (!win_found && rr_req[i]) begin
          win       = GW'(i);
          win_found = 1'b1;
        end
    end else begin
      for (int unsigned i = 1; i <= NM; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= NM) idx = idx - NM;
        if (!win_found && rr_req[idx]) begin
          win       = GW'(idx);
          win_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= GW'(NM - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    wd_d          = '0;
    busy_o        = 1'b0;
    timeout_o     = 1'b0;
    bus.wb_cyc_o  = 1'b0;
    bus.wb_stb_o  = 1'b0;
    bus.wb_we_o   = 1'b0;
    bus.wb_addr_o = '0;
    bus.wb_data_o = '0;
    bus.wb_sel_o  = '0;
    bus.m_ack_o   = '0;
    bus.m_err_o   = '0;
    bus.m_rty_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.m_cyc_i) begin
          state_d = BUSY;
          gnt_d   = win;
          ptr_d   = win;
        end
      end
      BUSY: begin
        busy_o        = 1'b1;
        bus.wb_cyc_o  = g_cyc;
        bus.wb_stb_o  = g_stb;
        bus.wb_we_o   = bus.m_we_i[gnt_q];
        bus.wb_addr_o = addr_a[gnt_q];
        bus.wb_data_o = data_a[gnt_q];
        bus.wb_sel_o  = sel_a[gnt_q];
        bus.m_ack_o   = {NM{bus.wb_ack_i}} & g_onehot;
        bus.m_err_o   = {NM{bus.wb_err_i | expire}} & g_onehot;
        bus.m_rty_o   = {NM{bus.wb_rty_i}} & g_onehot;
        timeout_o     = expire;
        if (stall) wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
        if (!g_cyc)      state_d = IDLE;
        else if (expire) state_d = HOLD;
        if (state_d != BUSY) wd_d = '0;
      end
      HOLD: begin
        if (!g_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_conmax_slave_if_n.sv
// Bench for wb_conmax_slave_if_n: one instance per arbitration mode (index =
// ARB_MODE) sharing the same stimulus; each check targets the relevant one.
module tb_wb_conmax_slave_if_n;
  localparam int NM = 8, AW = 32, DW = 32, SW = 4, TO_W = 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [2*NM-1:0]  conf;
  logic [TO_W-1:0]  to_limit;
  logic [NM*DW-1:0] m_data;
  logic [NM*AW-1:0] m_addr;
  logic [NM*SW-1:0] m_sel;
  logic [NM-1:0]    m_we, m_cyc, m_stb;
  logic [DW-1:0]    s_data;
  logic             s_ack, s_err, s_rty;

  logic [NM-1:0]    ack_v [3];
  logic [NM-1:0]    err_v [3];
  logic [NM-1:0]    rty_v [3];
  logic [NM*DW-1:0] mdat_v [3];
  logic [DW-1:0]    wdat_v [3];
  logic [AW-1:0]    addr_v [3];
  logic [SW-1:0]    sel_v [3];
  logic [2:0]       gnt_v [3];
  logic [2:0]       wbcyc_v, wbstb_v, wbwe_v, busy_v, tmo_v;

  int checks = 0, passes = 0, fails = 0;
  int exp_q[$];

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_conmax_slave_if_n_if #(.NM(NM), .AW(AW), .DW(DW), .SW(SW)) bus ();
    assign bus.m_data_i  = m_data;
    assign bus.m_addr_i  = m_addr;
    assign bus.m_sel_i   = m_sel;
    assign bus.m_we_i    = m_we;
    assign bus.m_cyc_i   = m_cyc;
    assign bus.m_stb_i   = m_stb;
    assign bus.wb_data_i = s_data;
    assign bus.wb_ack_i  = s_ack;
    assign bus.wb_err_i  = s_err;
    assign bus.wb_rty_i  = s_rty;
    assign ack_v[g]   = bus.m_ack_o;
    assign err_v[g]   = bus.m_err_o;
    assign rty_v[g]   = bus.m_rty_o;
    assign mdat_v[g]  = bus.m_data_o;
    assign wdat_v[g]  = bus.wb_data_o;
    assign addr_v[g]  = bus.wb_addr_o;
    assign sel_v[g]   = bus.wb_sel_o;
    assign wbcyc_v[g] = bus.wb_cyc_o;
    assign wbstb_v[g] = bus.wb_stb_o;
    assign wbwe_v[g]  = bus.wb_we_o;

    wb_conmax_slave_if_n #(
      .NM(NM), .AW(AW), .DW(DW), .SW(SW), .ARB_MODE(g), .TO_W(TO_W)
    ) u_dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .conf     (conf),
      .to_limit (to_limit),
      .bus      (bus.slave),
      .gnt_o    (gnt_v[g]),
      .busy_o   (busy_v[g]),
      .timeout_o(tmo_v[g])
    );
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    m_cyc = '0; m_stb = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    conf = '0; to_limit = '0;
    cyc();
    rst_ni = 1'b1;
  endtask

  // Grants expected on instance sel are already queued; each grant does one
  // acked transfer, then its master drops cyc for one cycle and re-requests.
  task automatic run_grants(input int sel, input logic [NM-1:0] r, input int n);
    int g, w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!busy_v[sel] && w < 8) begin
        cyc();
        w++;
      end
      check("arb_busy", busy_v[sel], 1);
      g = exp_q.pop_front();
      check("arb_gnt", gnt_v[sel], g);
      if (k > 0) check("arb_gap", w, 1);
      s_ack = 1'b1; #1;
      check("arb_ack", ack_v[sel], NM'(1) << g);
      cyc();
      s_ack = 1'b0;
      m_cyc[g] = 1'b0; m_stb[g] = 1'b0; #1;
      check("arb_drop_cyc", wbcyc_v[sel], 0);
      cyc();
      check("arb_idle", busy_v[sel], 0);
      m_cyc = r; m_stb = r;
    end
  endtask

  initial begin
    int w;
    conf = '0; to_limit = '0; m_cyc = '0; m_stb = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_data = 32'h5A5A_1234;
    for (int k = 0; k < NM; k++) begin
      m_data[k*DW +: DW] = 32'hD000_0000 + k;
      m_addr[k*AW +: AW] = 32'hA000_0000 + 32'(k * 16);
      m_sel[k*SW +: SW]  = 4'(k);
    end
    m_we = 8'hA5;
    #2;
    check("rst_busy", busy_v[1], 0);
    check("rst_gnt", gnt_v[1], 0);
    check("rst_wbcyc", wbcyc_v[1], 0);
    check("rst_resp", ack_v[1] | err_v[1] | rty_v[1], 0);
    check("rst_mdata", mdat_v[1], {NM{s_data}});
    cyc();
    rst_ni = 1'b1;

    // single request, round-robin instance
    m_cyc = 8'h04; m_stb = 8'h04; exp_q.push_back(2); #1;
    check("t1_pre_cyc", wbcyc_v[1], 0);
    cyc();
    check("t1_busy", busy_v[1], 1);
    check("t1_wbcyc", wbcyc_v[1], 1);
    check("t1_gnt", gnt_v[1], exp_q.pop_front());
    check("t1_addr", addr_v[1], 32'hA000_0020);
    check("t1_wdata", wdat_v[1], 32'hD000_0002);
    check("t1_sel_we", {sel_v[1], wbwe_v[1], wbstb_v[1]}, {4'h2, 1'b1, 1'b1});
    s_err = 1'b1; #1;
    check("t1_err", err_v[1], 8'h04);
    s_err = 1'b0; s_rty = 1'b1; #1;
    check("t1_rty", rty_v[1], 8'h04);
    s_rty = 1'b0; s_ack = 1'b1; #1;
    check("t1_ack", ack_v[1], 8'h04);
    cyc();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0; #1;
    check("t1_drop_wbcyc", wbcyc_v[1], 0);
    check("t1_drop_busy", busy_v[1], 1);
    cyc();
    check("t1_idle", busy_v[1], 0);

    // round-robin among m0, m3, m5
    do_reset();
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(0);
    m_cyc = 8'h29; m_stb = 8'h29;
    run_grants(1, 8'h29, 4);

    // priority levels: m1=1, m6=3, m7=3
    do_reset();
    conf = 16'hF004;
    exp_q.push_back(6); exp_q.push_back(7); exp_q.push_back(6);
    m_cyc = 8'hC2; m_stb = 8'hC2;
    cyc();
    check("fix_busy", busy_v[0], 1);
    check("fix_gnt", gnt_v[0], 1);
    run_grants(2, 8'hC2, 3);

    // watchdog expiry and HOLD
    do_reset();
    to_limit = 8'd4; m_cyc = 8'h10; m_stb = 8'h10;
    cyc();
    check("wd_busy", busy_v[1], 1);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) cyc();
      check("wd_err", err_v[1], (c == 4) ? 8'h10 : 8'h00);
      check("wd_tmo", tmo_v[1], (c == 4) ? 1 : 0);
    end
    cyc();
    check("wd_hold_cyc", wbcyc_v[1], 0);
    check("wd_hold_busy", busy_v[1], 0);
    check("wd_hold_err", err_v[1] | tmo_v[1], 0);
    s_ack = 1'b1; #1;
    check("wd_hold_ack", ack_v[1], 0);
    cyc();
    s_ack = 1'b0;
    check("wd_hold_cyc2", wbcyc_v[1], 0);
    m_cyc = '0; m_stb = '0;
    cyc();
    m_cyc = 8'h10; m_stb = 8'h10;
    cyc();
    check("wd_regrant", busy_v[1], 1);

    // watchdog disabled
    to_limit = '0; w = 0;
    for (int c = 0; c < 300; c++) begin
      if (tmo_v[1] || !busy_v[1] || err_v[1] != 0) w++;
      cyc();
    end
    check("wd_off", w, 0);
    m_cyc = '0; m_stb = '0;
    cyc();

    // ack in the expiry cycle wins
    to_limit = 8'd4; m_cyc = 8'h10; m_stb = 8'h10;
    cyc(); cyc(); cyc(); cyc();
    s_ack = 1'b1; #1;
    check("tie_ack", ack_v[1], 8'h10);
    check("tie_err", err_v[1], 0);
    check("tie_tmo", tmo_v[1], 0);
    cyc();
    s_ack = 1'b0;
    check("tie_busy", busy_v[1], 1);

    // master dropping cyc in the expiry cycle wins
    cyc(); cyc(); cyc();
    m_cyc = '0; m_stb = '0; #1;
    check("drop_tmo", tmo_v[1], 0);
    check("drop_err", err_v[1], 0);
    cyc();
    m_cyc = 8'h10; m_stb = 8'h10;
    cyc();
    check("drop_regrant", busy_v[1], 1);
    m_cyc = '0; m_stb = '0;
    cyc();

    // asynchronous reset mid-transfer
    to_limit = '0; m_cyc = 8'h04; m_stb = 8'h04;
    cyc();
    check("rr_busy", busy_v[1], 1);
    s_ack = 1'b1; #1;
    rst_ni = 1'b0; #1;
    check("rr_wbcyc", wbcyc_v[1], 0);
    check("rr_busy0", busy_v[1], 0);
    check("rr_gnt0", gnt_v[1], 0);
    check("rr_ack0", ack_v[1], 0);
    check("rr_mdata", mdat_v[1], {NM{s_data}});
    s_ack = 1'b0; m_cyc = 8'h80; m_stb = 8'h80;
    cyc();
    rst_ni = 1'b1; exp_q.push_back(7);
    cyc();
    check("rr_regrant", busy_v[1], 1);
    check("rr_gnt7", gnt_v[1], exp_q.pop_front());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
